// File: rtl/alu_reg_if.sv
// Operand/result bundle for the registered ALU.
// The master drives the operands and the operation select. The slave returns the registered result.
interface alu_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [5:0]       ALUFun;
    logic             Sign;
    logic [WIDTH-1:0] S;

    modport master (output A, output B, output ALUFun, output Sign, input  S);
    modport slave  (input  A, input  B, input  ALUFun, input  Sign, output S);
endinterface

// File: rtl/alu_reg.sv
// MIPS-style integer ALU with a single output register.
// ALUFun[5:4] selects the operation group: add/sub, logic, shift or compare.
// The result is loaded every clock and cleared by a synchronous active-low reset.
module alu_reg #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_reg_if.slave   bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] arith_res;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] shift_res;
    logic             cmp_flag;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic [SH_W-1:0]  sh;
    logic             a_neg;
    logic             a_zero;
    logic             lt;

    // Add/sub group: wraps modulo 2^WIDTH and never traps on overflow.
    always_comb begin
        arith_res = bus.ALUFun[0] ? (bus.A - bus.B) : (bus.A + bus.B);
    end

    // Logic group: only the listed codes are defined, and every other code yields zero.
    always_comb begin
        logic_res = '0;
        case (bus.ALUFun[3:0])
            4'b1000: logic_res = bus.A & bus.B;
            4'b1110: logic_res = bus.A | bus.B;
            4'b0110: logic_res = bus.A ^ bus.B;
            4'b0001: logic_res = ~(bus.A | bus.B);
            4'b1010: logic_res = bus.A;
            default: logic_res = '0;
        endcase
    end

    // Shift group: B is shifted by the low bits of A, and the upper bits of A are ignored.
    always_comb begin
        sh        = bus.A[SH_W-1:0];
        shift_res = '0;
        case (bus.ALUFun[1:0])
            2'b00:   shift_res = bus.B << sh;
            2'b01:   shift_res = bus.B >> sh;
            2'b11:   shift_res = WIDTH'($signed(bus.B) >>> sh);
            default: shift_res = '0;
        endcase
    end

    // Compare group: LT honours Sign, while the compare-with-zero codes always treat A as signed.
    always_comb begin
        a_neg    = bus.A[WIDTH-1];
        a_zero   = (bus.A == '0);
        lt       = bus.Sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
        cmp_flag = 1'b0;
        case (bus.ALUFun[3:1])
            3'b001:  cmp_flag = (bus.A == bus.B);
            3'b000:  cmp_flag = (bus.A != bus.B);
            3'b010:  cmp_flag = lt;
            3'b110:  cmp_flag = a_neg | a_zero;
            3'b101:  cmp_flag = a_neg;
            3'b111:  cmp_flag = ~a_neg & ~a_zero;
            default: cmp_flag = 1'b0;
        endcase
    end

    // Group select, which produces the next value of the result register.
    always_comb begin
        s_d = '0;
        case (bus.ALUFun[5:4])
            2'b00:   s_d = arith_res;
            2'b01:   s_d = logic_res;
            2'b10:   s_d = shift_res;
            default: s_d = {{(WIDTH-1){1'b0}}, cmp_flag};
        endcase
    end

    // Result register: reset has priority over any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) s_q <= '0;
        else        s_q <= s_d;
    end

    assign bus.S = s_q;
endmodule

// File: tb/tb_alu_reg.sv
// Bench for alu_reg. Each driven operation pushes its expected result onto a queue.
// The expectation is popped and compared after the edge that loads S.
module tb_alu_reg;
    logic clk = 1'b0;
    logic reset;
    alu_reg_if #(.WIDTH(32)) bus ();

    alu_reg #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Independent reference written from the operation table.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic sg);
        logic [4:0] s;
        logic       l;
        s = a[4:0];
        case (f[5:4])
            2'b00: return f[0] ? a + (~b + 32'd1) : a + b;
            2'b01: begin
                if (f[3:0] == 4'b1000) return a & b;
                if (f[3:0] == 4'b1110) return a | b;
                if (f[3:0] == 4'b0110) return a ^ b;
                if (f[3:0] == 4'b0001) return ~(a | b);
                if (f[3:0] == 4'b1010) return a;
                return 32'd0;
            end
            2'b10: begin
                if (f[1:0] == 2'b00) return b << s;
                if (f[1:0] == 2'b01) return b >> s;
                if (f[1:0] == 2'b11) return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
                return 32'd0;
            end
            default: begin
                if (sg && (a[31] != b[31])) l = a[31];
                else                        l = (a < b);
                case (f[3:1])
                    3'b001:  return {31'd0, a == b};
                    3'b000:  return {31'd0, a != b};
                    3'b010:  return {31'd0, l};
                    3'b110:  return {31'd0, a[31] || a == 0};
                    3'b101:  return {31'd0, a[31]};
                    3'b111:  return {31'd0, !a[31] && a != 0};
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    // Applies one operation at the falling edge, queues its expectation, and waits until just after the loading edge.
    task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input logic sg, input logic [31:0] e);
        @(negedge clk);
        reset = rst; bus.A = a; bus.B = b; bus.ALUFun = f; bus.Sign = sg;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd12345, 32'd54321, 6'b000000, 1'b0, 32'd0);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL reset_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL reset_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_arith;
        logic [5:0]  f[2] = '{6'b000000, 6'b000001};
        logic [31:0] r[2] = '{32'd66666, 32'hFFFF5C08};
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'd12345, 32'd54321, f[i], 1'b0, r[i]);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL arith_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL arith_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_logic;
        logic [5:0]  f[6] = '{6'b011000, 6'b011110, 6'b010110, 6'b010001, 6'b011010, 6'b010000};
        logic [31:0] r[6] = '{32'h00001031, 32'h0000F439, 32'h0000E408, 32'hFFFF0BC6, 32'h00003039, 32'h0};
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'd12345, 32'd54321, f[i], 1'b0, r[i]);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL logic_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL logic_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_shift;
        logic [31:0] a[7] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'h24, 32'd0};
        logic [31:0] b[7] = '{32'd54321, 32'd54321, 32'd54321, 32'h80000000, 32'd54321, 32'd54321, 32'h8000_1234};
        logic [5:0]  f[7] = '{6'b100000, 6'b100001, 6'b100011, 6'b100011, 6'b100010, 6'b100000, 6'b100011};
        logic [31:0] r[7] = '{32'h000D4310, 32'h00000D43, 32'h00000D43, 32'hF8000000, 32'h0,
                              32'h000D4310, 32'h8000_1234};
        logic [31:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, a[i], b[i], f[i], 1'b0, r[i]);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL shift_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL shift_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_compare;
        logic [31:0] a[7] = '{32'd54321, 32'd54321, 32'd12345, 32'd12345, 32'd12345, 32'd12345, 32'd12345};
        logic [5:0]  f[7] = '{6'b110011, 6'b110001, 6'b110001, 6'b110101, 6'b111101, 6'b111011, 6'b111111};
        logic [31:0] r[7] = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
        logic [31:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, a[i], 32'd54321, f[i], 1'b0, r[i]);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL cmp_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL cmp_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_lt_sign;
        logic [31:0] a[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd7, 32'hFFFFFFFF};
        logic [31:0] b[8] = '{32'd1, 32'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd1, 32'd7, 32'd1};
        logic [5:0]  f[8] = '{6'b110101, 6'b110101, 6'b110101, 6'b110101, 6'b111101, 6'b111111, 6'b110101, 6'b111011};
        logic        s[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] r[8] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, a[i], b[i], f[i], s[i], r[i]);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL lt_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL lt_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic        rs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [5:0]  f[5]  = '{6'b000000, 6'b011110, 6'b000001, 6'b000001, 6'b010000};
        logic [31:0] r[5]  = '{32'd66666, 32'h0000F439, 32'd0, 32'hFFFF5C08, 32'd0};
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(rs[i], 32'd12345, 32'd54321, f[i], 1'b0, r[i]);
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL midrst_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e) begin n_err++; $display("FAIL midrst_%0d: got %h want %h", i, bus.S, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, e;
        logic [5:0]  f;
        logic        sg;
        for (int i = 0; i < 300; i++) begin
            a  = $urandom();
            b  = $urandom();
            if (i % 4 == 0) a = a & 32'h0000_003F;
            if (i % 7 == 0) b = a;
            f  = 6'($urandom_range(0, 63));
            sg = 1'($urandom_range(0, 1));
            drive(1'b1, a, b, f, sg, model(a, b, f, sg));
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_%0d: queue empty", i); end
            else begin
                e = exp_q.pop_front();
                if (bus.S !== e)
                    begin n_err++; $display("FAIL b2b_%0d: A=%h B=%h F=%b Sg=%b got %h want %h",
                                            i, a, b, f, sg, bus.S, e); end
            end
        end
    endtask

    initial begin
        reset = 1'b0; bus.A = '0; bus.B = '0; bus.ALUFun = '0; bus.Sign = 1'b0;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_compare();
        test_lt_sign();
        test_reset_midstream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit MIPS-style integer ALU for the single-cycle/pipelined MIPS32 datapath.
- A 6-bit ALUFun code selects one of four operation groups: add/sub, bitwise logic, shift, compare.
- The result is registered once: one clock of latency, synchronous active-low reset.

Parameters:
- WIDTH, 32, datapath width. Shift amount is A[4:0]; only 32 is required to work.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; when 0 at a clock edge, S is cleared
- A  input  32  operand A; also the shift amount, A[4:0]
- B  input  32  operand B; also the value that is shifted
- ALUFun  input  6  operation select (encoding below)
- Sign  input  1  1 = signed compare for LT, 0 = unsigned
- S  output  32  registered result

Behaviour:
- Timing: the result is computed combinationally from A, B, ALUFun and Sign, and loaded into S on every rising clk edge while reset=1.
- Latency is exactly 1 cycle. There is no enable and no handshake.
- Reset: reset=0 at an edge gives S=0 after that edge. This overrides any operation, including mid-stream. Release resumes normal loading at the next edge.
- Group ALUFun[5:4]=00, arithmetic:
  - ALUFun[0]=0: S = A+B, modulo 2^32.
  - ALUFun[0]=1: S = A-B, modulo 2^32.
  - No overflow trap; ALUFun[3:1] is ignored.
- Group 01, logic (by ALUFun[3:0]):
  - 1000 = A&B
  - 1110 = A|B
  - 0110 = A^B
  - 0001 = ~(A|B)
  - 1010 = A (pass-through)
  - Any other code gives S=0.
- Group 10, shift (by ALUFun[1:0]; shift amount sh = A[4:0], A[31:5] ignored):
  - 00 = B<<sh (SLL)
  - 01 = B>>sh, logical, zero-fill (SRL)
  - 11 = B>>>sh, arithmetic, B[31] fill (SRA)
  - 10 gives S=0.
  - sh=0 gives S=B.
- Group 11, compare: S = {31'b0, flag}, with flag chosen by ALUFun[3:1]:
  - 001 EQ: A==B
  - 000 NEQ: A!=B
  - 010 LT: A<B. Signed two's-complement when Sign=1, unsigned when Sign=0.
  - 110 LEZ: A<=0
  - 101 LTZ: A<0
  - 111 GTZ: A>0
  - LEZ, LTZ and GTZ always treat A as signed, regardless of Sign.
  - Other codes give S=0. ALUFun[0] is ignored in this group.
- Boundaries for LT:
  - Signed mode: 0x80000000 < 0x7FFFFFFF is true.
  - Unsigned mode: 0xFFFFFFFF < 1 is false.
  - A==B gives LT=0.

Test Plan:
1. Reset and arithmetic:
   - Hold reset=0 for 2 edges → S=0.
   - Release, A=12345, B=54321, ALUFun=000000 → S=66666 one edge later.
   - ALUFun=000001 → S=0xFFFF5C08.
2. Logic, same A and B:
   - 011000 → 0x00001031
   - 011110 → 0x0000F439
   - 010110 → 0x0000E408
   - 010001 → 0xFFFF0BC6
   - 011010 → 0x00003039
3. Shift, A=4, B=54321:
   - 100000 → 0x000D4310
   - 100001 → 0x00000D43
   - 100011 → 0x00000D43
   - B=0x80000000 with 100011 → 0xF8000000.
   - A=0x00000024 (sh=4) with SLL → same result as A=4.
4. Compare, A=B=54321:
   - 110011 → 1
   - 110001 → 0
   - Then A=12345, B=54321:
     - 110001 → 1
     - 110101 (Sign=0) → 1
     - 111101 → 0
     - 111011 → 0
     - 111111 → 1
5. Signed versus unsigned LT:
   - A=0xFFFFFFFF, B=1, ALUFun=110101: Sign=1 → S=1; Sign=0 → S=0.
   - A=0, ALUFun=111101 → 1; ALUFun=111111 → 0.
6. Reset mid-stream:
   - Change ops every cycle, assert reset=0 for one edge → S=0 at that edge.
   - The next edge with reset=1 shows the current operation's result.
   - Undefined code 010000 → S=0.
